// File: rtl/inv_char_seq_if.sv
// rtl/inv_char_seq_if.sv - control, stimulus and result signals of the inverter characterisation sequencer
interface inv_char_seq_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  logic             ena;
  logic             start;
  logic [DIV_W-1:0] half_period;
  logic [CNT_W-1:0] n_samples;
  logic             inv_out;
  logic             stim;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             any_fail;

  modport master (
    output ena, start, half_period, n_samples, inv_out,
    input  stim, busy, done, pass_cnt, fail_cnt, any_fail
  );

  modport slave (
    input  ena, start, half_period, n_samples, inv_out,
    output stim, busy, done, pass_cnt, fail_cnt, any_fail
  );
endinterface

// File: rtl/inv_char_seq.sv
// rtl/inv_char_seq.sv - square-wave stimulus and pass/fail scoring sequencer for the analog inverter tile
module inv_char_seq #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  inv_char_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             s1, s2;
  logic [DIV_W-1:0] hp, hc, hp_in;
  logic [CNT_W-1:0] rem;
  logic             stim_q;
  logic [CNT_W-1:0] pass_q, fail_q;
  logic             any_fail_q;
  logic             accept, sample, last;

  assign hp_in  = (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
  assign accept = (state == IDLE) && bus.start && bus.ena;
  assign sample = (state == RUN) && bus.ena && (hc == '0);
  assign last   = sample && (rem == CNT_W'(1));

  // inv_out is asynchronous to clk; only s2 is ever scored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.inv_out;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (bus.n_samples == '0) ? DONE : RUN;
      RUN: begin
        if (!bus.ena)  state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp         <= '0;
      hc         <= '0;
      rem        <= '0;
      stim_q     <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      any_fail_q <= 1'b0;
    end else if (accept) begin
      hp         <= hp_in;
      hc         <= hp_in - DIV_W'(1);
      rem        <= bus.n_samples;
      stim_q     <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
      any_fail_q <= 1'b0;
    end else if (state == RUN) begin
      if (!bus.ena) begin
        stim_q <= 1'b0;
      end else if (sample) begin
        if (s2 == ~stim_q) begin
          pass_q <= pass_q + CNT_W'(1);
        end else begin
          fail_q     <= fail_q + CNT_W'(1);
          any_fail_q <= 1'b1;
        end
        // the final sample leaves stim low so DONE always presents 0
        if (last) begin
          stim_q <= 1'b0;
        end else begin
          rem    <= rem - CNT_W'(1);
          stim_q <= ~stim_q;
          hc     <= hp - DIV_W'(1);
        end
      end else begin
        hc <= hc - DIV_W'(1);
      end
    end else begin
      stim_q <= 1'b0;
    end
  end

  assign bus.stim     = stim_q;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.pass_cnt = pass_q;
  assign bus.fail_cnt = fail_q;
  assign bus.any_fail = any_fail_q;

endmodule

// File: tb/tb_inv_char_seq.sv
// tb/tb_inv_char_seq.sv - directed self-checking bench for inv_char_seq with behavioural inverter models
module tb_inv_char_seq;

  localparam int MAXC = 150;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mode = 0;
  logic [7:0] hist = '0;

  int tr_stim [0:MAXC];
  int tr_busy [0:MAXC];
  int tr_done [0:MAXC];
  int tr_pass [0:MAXC];

  inv_char_seq_if #(.DIV_W(8), .CNT_W(8)) ifc ();

  inv_char_seq #(.DIV_W(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // mode 0: ideal inverter, 1: stuck follower, 2: ~stim delayed 5 cycles (7 cycles stim to s2)
  always @(posedge clk) hist <= {hist[6:0], ifc.stim};

  always_comb begin
    case (mode)
      1:       ifc.inv_out = ifc.stim;
      2:       ifc.inv_out = ~hist[4];
      default: ifc.inv_out = ~ifc.stim;
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int hp, input int n, input int md, input int abort_at,
                     input int pulse_at, output int done_at);
    mode = md;
    @(negedge clk);
    ifc.half_period = 8'(hp);
    ifc.n_samples   = 8'(n);
    ifc.ena         = 1'b1;
    ifc.start       = 1'b1;
    done_at = -1;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      tr_stim[k] = int'(ifc.stim);
      tr_busy[k] = int'(ifc.busy);
      tr_done[k] = int'(ifc.done);
      tr_pass[k] = int'(ifc.pass_cnt);
      if (done_at < 0 && ifc.done) done_at = k;
      ifc.start = (k == pulse_at);
      if (k == abort_at) ifc.ena = 1'b0;
      if (done_at > 0 && k >= done_at + 2) break;
      if (abort_at > 0 && k >= abort_at + 3) break;
    end
    ifc.start = 1'b0;
    ifc.ena   = 1'b1;
  endtask

  // Expected stim is a square wave starting low, toggling after every hp cycles, low again in DONE
  function automatic int stim_errs(input int hp, input int n, input int last_cyc);
    int e = 0;
    int h = (hp == 0) ? 1 : hp;
    for (int k = 1; k <= last_cyc; k++) begin
      int exp_s = (k <= n * h) ? (((k - 1) / h) % 2) : 0;
      if (tr_stim[k] != exp_s) e++;
    end
    return e;
  endfunction

  function automatic int busy_sum(input int last_cyc);
    int s = 0;
    for (int k = 1; k <= last_cyc; k++) s += tr_busy[k];
    return s;
  endfunction

  int d;

  initial begin
    ifc.ena = 1'b0;
    ifc.start = 1'b0;
    ifc.half_period = '0;
    ifc.n_samples = '0;
    repeat (3) @(negedge clk);
    check("rst_stim", int'(ifc.stim), 0);
    check("rst_busy", int'(ifc.busy), 0);
    check("rst_done", int'(ifc.done), 0);
    check("rst_pass", int'(ifc.pass_cnt), 0);
    check("rst_fail", int'(ifc.fail_cnt), 0);
    check("rst_any", int'(ifc.any_fail), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(4, 6, 0, 0, 0, d);
    check("ideal_done_cyc", d, 25);
    check("ideal_stim_trace", stim_errs(4, 6, 25), 0);
    check("ideal_busy_cycles", busy_sum(25), 24);
    check("ideal_pass", int'(ifc.pass_cnt), 6);
    check("ideal_fail", int'(ifc.fail_cnt), 0);
    check("ideal_any", int'(ifc.any_fail), 0);

    run(5, 3, 1, 0, 0, d);
    check("stuck_done_cyc", d, 16);
    check("stuck_pass", int'(ifc.pass_cnt), 0);
    check("stuck_fail", int'(ifc.fail_cnt), 3);
    check("stuck_any", int'(ifc.any_fail), 1);

    run(3, 2, 0, 0, 0, d);
    check("rerun_done_cyc", d, 7);
    check("rerun_pass", int'(ifc.pass_cnt), 2);
    check("rerun_fail", int'(ifc.fail_cnt), 0);
    check("rerun_any", int'(ifc.any_fail), 0);

    repeat (10) @(negedge clk);
    run(4, 4, 2, 0, 0, d);
    check("delay_done_cyc", d, 17);
    check("delay_pass", int'(ifc.pass_cnt), 1);
    check("delay_fail", int'(ifc.fail_cnt), 3);
    check("delay_any", int'(ifc.any_fail), 1);

    run(4, 0, 0, 0, 0, d);
    check("n0_done_cyc", d, 1);
    check("n0_busy_cycles", busy_sum(3), 0);
    check("n0_stim_trace", stim_errs(4, 0, 3), 0);
    check("n0_pass", int'(ifc.pass_cnt), 0);
    check("n0_fail", int'(ifc.fail_cnt), 0);
    check("n0_any", int'(ifc.any_fail), 0);

    run(0, 2, 0, 0, 3, d);
    check("hp0_done_cyc", d, 3);
    check("hp0_stim_trace", stim_errs(0, 2, 3), 0);
    check("start_in_done_busy", tr_busy[4], 0);
    check("start_in_done_done", tr_done[4], 0);

    run(4, 10, 0, 13, 6, d);
    check("abort_no_done", d, -1);
    check("abort_busy_c13", tr_busy[13], 1);
    check("abort_pass_c13", tr_pass[13], 3);
    check("abort_busy_c14", tr_busy[14], 0);
    check("abort_stim_c14", tr_stim[14], 0);
    check("abort_pass_c16", tr_pass[16], 3);

    mode = 0;
    @(negedge clk);
    ifc.half_period = 8'd4;
    ifc.n_samples   = 8'd6;
    ifc.start       = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_pass", int'(ifc.pass_cnt), 2);
    check("pre_rst_busy", int'(ifc.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_stim", int'(ifc.stim), 0);
    check("async_rst_busy", int'(ifc.busy), 0);
    check("async_rst_pass", int'(ifc.pass_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(3, 2, 0, 0, 0, d);
    check("post_rst_done_cyc", d, 7);
    check("post_rst_pass", int'(ifc.pass_cnt), 2);
    check("post_rst_fail", int'(ifc.fail_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
